// File: rtl/coproc_feed_ctrl_if.sv
// Pixel-source (valid/ready) and coprocessor (novodado/dadorecebido) signal bundle.
// The master modport is the feed controller; the slave side is the source plus coprocessor.
interface coproc_feed_ctrl_if;
  logic [31:0] src_data;
  logic        src_valid;
  logic        src_ready;
  logic [31:0] pixel_export;
  logic        novodado;
  logic        dadorecebido;

  modport master (
    input  src_data, src_valid, dadorecebido,
    output src_ready, pixel_export, novodado
  );

  modport slave (
    output src_data, src_valid, dadorecebido,
    input  src_ready, pixel_export, novodado
  );
endinterface

// File: rtl/coproc_feed_ctrl.sv
// Feeds one frame of packed grey pixels from a valid/ready source into the edge
// coprocessor over a 4-phase novodado/dadorecebido handshake, with a phase watchdog.
module coproc_feed_ctrl #(
  parameter int unsigned IMG_W   = 64,
  parameter int unsigned IMG_H   = 64,
  parameter int unsigned TIMEOUT = 1023,
  localparam int unsigned WORDS  = IMG_W * IMG_H / 4,
  localparam int unsigned CNT_W  = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic               clock_50MHz,
  input  logic               reset,
  input  logic               start,
  coproc_feed_ctrl_if.master bus,
  output logic               busy,
  output logic               frame_done,
  output logic               timeout_err,
  output logic [CNT_W-1:0]   word_count
);

  localparam int unsigned WD_W    = 16;
  localparam bit          WD_EN   = (TIMEOUT != 0);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_SRC, S_ASSERT, S_RELEASE, S_DONE, S_ERROR
  } state_t;

  state_t           r_state, w_state_nx;
  logic [31:0]      r_pix, w_pix_nx;
  logic [WD_W-1:0]  r_wd, w_wd_nx;
  logic [CNT_W-1:0] r_cnt, w_cnt_nx;
  logic             r_to, w_to_nx;
  logic             r_src_ready, r_novodado, r_busy, r_done;
  logic             w_xfer, w_wd_hit;

  assign w_xfer   = (r_state == S_WAIT_SRC) && bus.src_valid && r_src_ready;
  assign w_wd_hit = WD_EN && (r_wd == WD_LAST);

  // Next-state, datapath and watchdog decisions
  always_comb begin
    w_state_nx = r_state;
    w_pix_nx   = r_pix;
    w_wd_nx    = r_wd;
    w_cnt_nx   = r_cnt;
    w_to_nx    = r_to;
    case (r_state)
      S_IDLE, S_ERROR: begin
        if (start) begin
          w_state_nx = S_WAIT_SRC;
          w_cnt_nx   = '0;
          w_to_nx    = 1'b0;
        end
      end
      S_WAIT_SRC: begin
        if (w_xfer) begin
          w_state_nx = S_ASSERT;
          w_pix_nx   = bus.src_data;
          w_wd_nx    = '0;
        end
      end
      S_ASSERT: begin
        if (bus.dadorecebido) begin
          w_state_nx = S_RELEASE;
          w_wd_nx    = '0;
        end else if (w_wd_hit) begin
          w_state_nx = S_ERROR;
          w_to_nx    = 1'b1;
        end else begin
          w_wd_nx = r_wd + WD_W'(1);
        end
      end
      S_RELEASE: begin
        // Acknowledge release takes priority over a same-cycle watchdog expiry
        if (!bus.dadorecebido) begin
          if (r_cnt == CNT_LAST) begin
            w_state_nx = S_DONE;
            w_cnt_nx   = '0;
          end else begin
            w_state_nx = S_WAIT_SRC;
            w_cnt_nx   = r_cnt + CNT_W'(1);
          end
        end else if (w_wd_hit) begin
          w_state_nx = S_ERROR;
          w_to_nx    = 1'b1;
        end else begin
          w_wd_nx = r_wd + WD_W'(1);
        end
      end
      S_DONE:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_50MHz or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_pix       <= '0;
      r_wd        <= '0;
      r_cnt       <= '0;
      r_to        <= 1'b0;
      r_src_ready <= 1'b0;
      r_novodado  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_pix       <= w_pix_nx;
      r_wd        <= w_wd_nx;
      r_cnt       <= w_cnt_nx;
      r_to        <= w_to_nx;
      // Outputs registered from the next state so they line up with the state they describe
      r_src_ready <= (w_state_nx == S_WAIT_SRC) && !bus.dadorecebido;
      r_novodado  <= (w_state_nx == S_ASSERT);
      r_busy      <= (w_state_nx == S_WAIT_SRC) || (w_state_nx == S_ASSERT) ||
                     (w_state_nx == S_RELEASE);
      r_done      <= (w_state_nx == S_DONE);
    end
  end

  assign bus.src_ready    = r_src_ready;
  assign bus.pixel_export = r_pix;
  assign bus.novodado     = r_novodado;
  assign busy             = r_busy;
  assign frame_done       = r_done;
  assign timeout_err      = r_to;
  assign word_count       = r_cnt;

endmodule
